// File: rtl/display_scan_driver_pkg.sv
// Shared constants and state encoding for the display scan driver.
package display_scan_driver_pkg;

  localparam int unsigned REFRESH_DIV_DEFAULT    = 100000;
  localparam int unsigned PRESCALE_WIDTH_DEFAULT = 17;
  localparam int unsigned DISPLAY_WIDTH          = 8;
  localparam int unsigned NIBBLE_WIDTH           = 4;

  typedef enum logic {
    STATE_EMPTY = 1'b0,
    STATE_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/display_scan_driver_refresh_prescaler.sv
// Divides the system clock into digit-slot ticks and toggles the digit select.
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned PRESCALE_WIDTH = 17
) (
  input  logic clock,
  input  logic resetN,
  output logic tick,
  output logic counter
);

  localparam logic [PRESCALE_WIDTH-1:0] LAST = PRESCALE_WIDTH'(REFRESH_DIV - 1);

  logic [PRESCALE_WIDTH-1:0] prescaler;

  // Wrap is an explicit compare, so REFRESH_DIV need not be a power of two.
  assign tick = (prescaler == LAST);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      prescaler <= '0;
      counter   <= 1'b0;
    end else if (tick) begin
      prescaler <= '0;
      counter   <= ~counter;
    end else begin
      prescaler <= prescaler + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// Byte intake with a one-deep pending buffer committed to the display only at frame boundaries.
module display_scan_driver
  import display_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = REFRESH_DIV_DEFAULT,
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [DISPLAY_WIDTH-1:0] dataIn,
  input  logic                     dataValid,
  output logic                     dataReady,
  output logic                     counter,
  output logic [NIBBLE_WIDTH-1:0]  segment2,
  output logic [NIBBLE_WIDTH-1:0]  segment1,
  output logic                     frameTick
);

  state_t                   state_q, state_d;
  logic                     started_q;
  logic                     tick;
  logic                     boundary;
  logic                     accept;
  logic                     commit;
  logic                     frame_tick_q;
  logic [DISPLAY_WIDTH-1:0] pending_q;
  logic [DISPLAY_WIDTH-1:0] display_q;

  refresh_prescaler #(
    .REFRESH_DIV    (REFRESH_DIV),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clock   (clock),
    .resetN  (resetN),
    .tick    (tick),
    .counter (counter)
  );

  // End of slot B: both digits have been scanned since the last boundary.
  assign boundary = tick & counter;

  // started_q keeps ready low until the first edge after reset release.
  assign dataReady = started_q & (state_q == STATE_EMPTY);
  assign accept    = dataValid & dataReady;
  assign commit    = (state_q == STATE_FULL) & boundary;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_EMPTY: if (accept) state_d = STATE_FULL;
      STATE_FULL:  if (boundary) state_d = STATE_EMPTY;
      default:     state_d = STATE_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= STATE_EMPTY;
      started_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      pending_q    <= '0;
      display_q    <= '0;
    end else begin
      state_q      <= state_d;
      started_q    <= 1'b1;
      frame_tick_q <= boundary;
      if (accept) pending_q <= dataIn;
      if (commit) display_q <= pending_q;
    end
  end

  assign frameTick = frame_tick_q;
  assign segment2  = display_q[DISPLAY_WIDTH-1:NIBBLE_WIDTH];
  assign segment1  = display_q[NIBBLE_WIDTH-1:0];

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench: accepted bytes queued with their expected commit edge, monitor pops and compares.
module tb_display_scan_driver;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = 2 * DIV;

  logic       clock;
  logic       resetN;
  logic [7:0] dataIn;
  logic       dataValid;
  logic       dataReady;
  logic       counter;
  logic [3:0] segment2;
  logic [3:0] segment1;
  logic       frameTick;

  display_scan_driver #(
    .REFRESH_DIV    (DIV),
    .PRESCALE_WIDTH (3)
  ) dut (
    .clock     (clock),
    .resetN    (resetN),
    .dataIn    (dataIn),
    .dataValid (dataValid),
    .dataReady (dataReady),
    .counter   (counter),
    .segment2  (segment2),
    .segment1  (segment1),
    .frameTick (frameTick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  b;
    int unsigned at_edge;
  } exp_t;

  exp_t        q[$];
  int unsigned edges;
  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned n_commits;
  logic [7:0]  mon_disp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edges, $time);
    end
  endtask

  // Reference: edges counted since reset release; boundaries fall on multiples of FRAME,
  // a byte is accepted whenever nothing is pending (from edge 2 on) and commits at the next boundary.
  always @(posedge clock) begin
    if (!resetN) begin
      edges = 0;
      q.delete();
    end else begin
      edges++;
      if (edges >= 2 && q.size() == 0 && dataValid === 1'b1) begin
        exp_t e;
        e.b       = dataIn;
        e.at_edge = ((edges / FRAME) + 1) * FRAME;
        q.push_back(e);
      end
    end
  end

  always @(negedge clock) begin
    if (!resetN) begin
      edges    = 0;
      mon_disp = 8'h00;
      q.delete();
      chk("rst_ready", {31'b0, dataReady}, 0);
      chk("rst_counter", {31'b0, counter}, 0);
      chk("rst_frametick", {31'b0, frameTick}, 0);
      chk("rst_segments", {24'b0, segment2, segment1}, 0);
    end else begin
      if (q.size() > 0 && q[0].at_edge == edges) begin
        exp_t e;
        e = q.pop_front();
        mon_disp = e.b;
        n_commits++;
      end
      chk("segments", {24'b0, segment2, segment1}, {24'b0, mon_disp});
      chk("ready", {31'b0, dataReady}, {31'b0, (edges >= 1 && q.size() == 0)});
      chk("counter", {31'b0, counter}, ((edges / DIV) % 2));
      chk("frametick", {31'b0, frameTick}, {31'b0, (edges > 0 && (edges % FRAME) == 0)});
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clock);
    #2;
    dataValid = v;
    dataIn    = d;
  endtask

  // Bounded wait until the next edge index satisfies (edges+1) % FRAME == phase.
  task automatic wait_phase(input int unsigned phase);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (((edges + 1) % FRAME) == phase) return;
      drive(1'b0, 8'h00);
    end
    chk("wait_phase_timeout", 1, 0);
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(posedge clock);
    #2;
    resetN    = 1'b0;
    dataValid = 1'b0;
    repeat (cycles) @(posedge clock);
    #2;
    resetN = 1'b1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    n_commits = 0;
    edges     = 0;
    mon_disp  = 8'h00;
    resetN    = 1'b1;
    dataValid = 1'b0;
    dataIn    = 8'h00;
    #1 resetN = 1'b0;

    // Reset then idle
    do_reset(3);
    repeat (3 * FRAME) drive(1'b0, 8'h00);

    // Single write mid slot A
    wait_phase(2);
    drive(1'b1, 8'hA5);
    drive(1'b0, 8'h00);
    repeat (2 * FRAME) drive(1'b0, 8'h00);

    // Write presented on the boundary edge
    wait_phase(0);
    drive(1'b1, 8'h3C);
    drive(1'b0, 8'h00);
    repeat (3 * FRAME) drive(1'b0, 8'h00);

    // Back-pressure with a changing byte every cycle
    for (int unsigned i = 1; i <= 5 * FRAME; i++) drive(1'b1, 8'(i * 8'h11));
    drive(1'b0, 8'h00);
    repeat (2 * FRAME) drive(1'b0, 8'h00);

    // Reset while a byte is pending
    wait_phase(3);
    drive(1'b1, 8'hF0);
    drive(1'b0, 8'h00);
    do_reset(2);
    repeat (3 * FRAME) drive(1'b0, 8'h00);

    // Random traffic
    for (int i = 0; i < 1000; i++) drive($urandom_range(0, 3) == 0, 8'($urandom));
    drive(1'b0, 8'h00);
    repeat (3 * FRAME) drive(1'b0, 8'h00);

    chk("commits_seen", {31'b0, (n_commits >= 10)}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
